// File: rtl/ddu_pkg.sv
// Shared definitions for the debug display unit memory loader:
// FSM encoding, chunk field layout and debounce default.
package ddu_pkg;

  localparam logic [0:0] ST_IDLE  = 1'b0;
  localparam logic [0:0] ST_WRITE = 1'b1;

  localparam int DEBOUNCE_DEFAULT = 50000;

  localparam int CHUNK_W    = 12;
  localparam int CHUNK0_LSB = 0;
  localparam int CHUNK1_LSB = 12;
  localparam int CHUNK2_LSB = 24;
  localparam int CHUNK2_W   = 8;

  localparam logic [1:0] CHUNK_LAST = 2'd2;

  // The third chunk only has room for the low 8 switch bits.
  function automatic logic [31:0] insert_chunk(input logic [31:0]        word,
                                               input logic [1:0]         idx,
                                               input logic [CHUNK_W-1:0] sw);
    logic [31:0] result;
    result = word;
    case (idx)
      2'd0:    result[CHUNK0_LSB +: CHUNK_W]  = sw;
      2'd1:    result[CHUNK1_LSB +: CHUNK_W]  = sw;
      2'd2:    result[CHUNK2_LSB +: CHUNK2_W] = sw[CHUNK2_W-1:0];
      default: result = word;
    endcase
    return result;
  endfunction

endpackage

// File: rtl/btn_debounce.sv
// Push-button conditioning: 2-flop synchronizer, stability counter and
// a one-cycle pulse on each debounced 0->1 transition.
module btn_debounce #(
  parameter int DEBOUNCE_CYCLES = ddu_pkg::DEBOUNCE_DEFAULT
) (
  input  logic clk_5M,
  input  logic reset,
  input  logic btn_raw,
  output logic level,
  output logic press
);

  localparam int CNT_W = $clog2(DEBOUNCE_CYCLES + 1);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

  logic             sync_q1;
  logic             sync_q2;
  logic [CNT_W-1:0] stable_cnt;
  logic             level_d;

  // NOTE: sequential state uses non-blocking assignments so every flop
  // samples pre-edge values regardless of statement order.
  always_ff @(posedge clk_5M or posedge reset) begin
    if (reset) begin
      sync_q1 <= 1'b0;
      sync_q2 <= 1'b0;
    end else begin
      sync_q1 <= btn_raw;
      sync_q2 <= sync_q1;
    end
  end

  // Level flips only after an unbroken run of disagreeing samples.
  always_ff @(posedge clk_5M or posedge reset) begin
    if (reset) begin
      stable_cnt <= '0;
      level      <= 1'b0;
    end else if (sync_q2 != level) begin
      if (stable_cnt == CNT_LAST) begin
        level      <= sync_q2;
        stable_cnt <= '0;
      end else begin
        stable_cnt <= stable_cnt + 1'b1;
      end
    end else begin
      stable_cnt <= '0;
    end
  end

  always_ff @(posedge clk_5M or posedge reset) begin
    if (reset) level_d <= 1'b0;
    else       level_d <= level;
  end

  assign press = level & ~level_d;

endmodule

// File: rtl/ddu_mem_loader.sv
// Assembles a 32-bit word from three 12-bit switch entries and issues one
// acknowledged write per word to the data memory debug port.
module ddu_mem_loader
  import ddu_pkg::*;
#(
  parameter int DEBOUNCE_CYCLES = DEBOUNCE_DEFAULT,
  parameter int ADDR_W          = 8
) (
  input  logic              clk_5M,
  input  logic              reset,
  input  logic [11:0]       sw_data,
  input  logic              load_btn,
  input  logic              abort,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [31:0]       mem_wdata,
  output logic              mem_we,
  input  logic              mem_ack,
  output logic [1:0]        chunk_idx,
  output logic              busy,
  output logic [7:0]        wr_count
);

  logic       state;
  logic       btn_level;
  logic       press;

  btn_debounce #(
    .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
  ) u_deb (
    .clk_5M (clk_5M),
    .reset  (reset),
    .btn_raw(load_btn),
    .level  (btn_level),
    .press  (press)
  );

  // Presses and aborts are only honoured in IDLE; a committed request
  // stays on the bus until the memory acknowledges it.
  always_ff @(posedge clk_5M or posedge reset) begin
    if (reset) begin
      state     <= ST_IDLE;
      mem_addr  <= '0;
      mem_wdata <= '0;
      mem_we    <= 1'b0;
      busy      <= 1'b0;
      chunk_idx <= 2'd0;
      wr_count  <= 8'd0;
    end else begin
      case (state)
        ST_IDLE: begin
          if (abort) begin
            chunk_idx <= 2'd0;
          end else if (press) begin
            mem_wdata <= insert_chunk(mem_wdata, chunk_idx, sw_data);
            if (chunk_idx == CHUNK_LAST) begin
              chunk_idx <= 2'd0;
              mem_we    <= 1'b1;
              busy      <= 1'b1;
              state     <= ST_WRITE;
            end else begin
              chunk_idx <= chunk_idx + 2'd1;
            end
          end
        end
        ST_WRITE: begin
          if (mem_ack) begin
            mem_we   <= 1'b0;
            busy     <= 1'b0;
            mem_addr <= mem_addr + 1'b1;
            wr_count <= wr_count + 8'd1;
            state    <= ST_IDLE;
          end
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

  logic unused_level;
  assign unused_level = btn_level;

endmodule

// File: tb/tb_ddu_mem_loader.sv
// Self-checking bench for ddu_mem_loader: randomized words against a
// word-level reference model, plus debounce, abort, wrap and reset cases.
module tb_ddu_mem_loader;

  logic        clk_5M = 1'b0;
  logic        reset = 1'b0;
  logic [11:0] sw_data = '0;
  logic        load_btn = 1'b0;
  logic        abort = 1'b0;
  logic        mem_ack = 1'b0;
  logic [7:0]  mem_addr;
  logic [31:0] mem_wdata;
  logic        mem_we;
  logic [1:0]  chunk_idx;
  logic        busy;
  logic [7:0]  wr_count;

  int total = 0;
  int bad = 0;

  // Reference model: the three entered chunks, next chunk, address, count.
  logic [11:0] parts [3];
  logic [1:0]  m_chunk;
  logic [7:0]  m_addr;
  logic [7:0]  m_cnt;
  logic        m_busy;

  ddu_mem_loader #(
    .DEBOUNCE_CYCLES(4),
    .ADDR_W         (8)
  ) u_dut (
    .clk_5M   (clk_5M),
    .reset    (reset),
    .sw_data  (sw_data),
    .load_btn (load_btn),
    .abort    (abort),
    .mem_addr (mem_addr),
    .mem_wdata(mem_wdata),
    .mem_we   (mem_we),
    .mem_ack  (mem_ack),
    .chunk_idx(chunk_idx),
    .busy     (busy),
    .wr_count (wr_count)
  );

  always #100 clk_5M = ~clk_5M;

  function automatic logic [31:0] m_word();
    return {parts[2][7:0], parts[1], parts[0]};
  endfunction

  function automatic logic [51:0] exp_vec();
    return {m_busy, m_busy, m_chunk, m_addr, m_cnt, m_word()};
  endfunction

  logic [51:0] obs_vec;
  assign obs_vec = {mem_we, busy, chunk_idx, mem_addr, wr_count, mem_wdata};

  task automatic m_reset();
    for (int i = 0; i < 3; i++) parts[i] = '0;
    m_chunk = 2'd0;
    m_addr  = 8'd0;
    m_cnt   = 8'd0;
    m_busy  = 1'b0;
  endtask

  task automatic press_raw(input logic [11:0] sw);
    @(negedge clk_5M);
    sw_data  = sw;
    load_btn = 1'b1;
    repeat (9) @(negedge clk_5M);
    load_btn = 1'b0;
    repeat (9) @(negedge clk_5M);
  endtask

  task automatic press(input logic [11:0] sw);
    press_raw(sw);
    if (!m_busy) begin
      parts[m_chunk] = sw;
      if (m_chunk == 2'd2) begin
        m_chunk = 2'd0;
        m_busy  = 1'b1;
      end else begin
        m_chunk = m_chunk + 2'd1;
      end
    end
  endtask

  task automatic press_word(input logic [11:0] a, input logic [11:0] b, input logic [11:0] c);
    press(a);
    press(b);
    press(c);
  endtask

  task automatic wait_we(input string name);
    int n = 0;
    while (!mem_we && n < 50) begin
      @(negedge clk_5M);
      n++;
    end
    total++;
    if (mem_we !== 1'b1) begin
      bad++;
      $display("FAIL %s: mem_we timeout got=%b want=1", name, mem_we);
    end
  endtask

  task automatic ack_after(input int delay);
    repeat (delay) @(negedge clk_5M);
    mem_ack = 1'b1;
    @(negedge clk_5M);
    mem_ack = 1'b0;
    m_busy = 1'b0;
    m_addr = m_addr + 8'd1;
    m_cnt  = m_cnt + 8'd1;
  endtask

  task automatic test_reset();
    #1 reset = 1'b1;
    m_reset();
    repeat (3) @(negedge clk_5M);
    total++;
    if (obs_vec !== exp_vec()) begin
      bad++;
      $display("FAIL reset_state: got=%h want=%h", obs_vec, exp_vec());
    end
    reset = 1'b0;
    @(negedge clk_5M);
  endtask

  task automatic test_debounce();
    logic [1:0]  prev;
    logic [11:0] sw;
    int changes = 0;
    int first = -1;
    sw = 12'($urandom);
    sw_data = sw;
    prev = chunk_idx;
    for (int c = 0; c < 20; c++) begin
      load_btn = ((c / 2) % 2 == 0);
      @(negedge clk_5M);
      if (chunk_idx !== prev) changes++;
      prev = chunk_idx;
    end
    for (int c = 0; c < 20; c++) begin
      load_btn = (c < 10);
      @(negedge clk_5M);
      if (chunk_idx !== prev) begin
        changes++;
        if (first < 0) first = c + 1;
      end
      prev = chunk_idx;
    end
    parts[0] = sw;
    m_chunk  = 2'd1;
    total++;
    if (changes != 1) begin
      bad++;
      $display("FAIL debounce_count: got=%0d presses want=1", changes);
    end
    total++;
    if (first < 4 || first > 9) begin
      bad++;
      $display("FAIL debounce_latency: got=%0d cycles want=4..9", first);
    end
    total++;
    if (obs_vec !== exp_vec()) begin
      bad++;
      $display("FAIL debounce_state: got=%h want=%h", obs_vec, exp_vec());
    end
  endtask

  task automatic test_full_word();
    @(negedge clk_5M);
    abort = 1'b1;
    @(negedge clk_5M);
    abort = 1'b0;
    m_chunk = 2'd0;
    press_word(12'hABC, 12'h123, 12'hF45);
    wait_we("full_word");
    total++;
    if (mem_wdata !== 32'h45123ABC || mem_addr !== 8'd0) begin
      bad++;
      $display("FAIL full_word_data: got=%h@%h want=45123abc@00", mem_wdata, mem_addr);
    end
    total++;
    if (obs_vec !== exp_vec()) begin
      bad++;
      $display("FAIL full_word_state: got=%h want=%h", obs_vec, exp_vec());
    end
    ack_after(3);
    total++;
    if (mem_we !== 1'b0 || mem_addr !== 8'd1 || wr_count !== 8'd1) begin
      bad++;
      $display("FAIL full_word_ack: got we=%b addr=%h cnt=%h want 0/01/01", mem_we, mem_addr, wr_count);
    end
  endtask

  task automatic test_ack_hold();
    logic [51:0] snap;
    press_word(12'($urandom), 12'($urandom), 12'($urandom));
    wait_we("ack_hold");
    snap = exp_vec();
    for (int i = 0; i < 100; i++) begin
      load_btn = (i >= 10 && i < 30);
      sw_data  = 12'($urandom);
      @(negedge clk_5M);
      total++;
      if (obs_vec !== snap) begin
        bad++;
        $display("FAIL ack_hold_stable cycle %0d: got=%h want=%h", i, obs_vec, snap);
      end
    end
    ack_after(0);
    total++;
    if (obs_vec !== exp_vec() || chunk_idx !== 2'd0) begin
      bad++;
      $display("FAIL ack_hold_after: got=%h want=%h", obs_vec, exp_vec());
    end
  endtask

  task automatic test_abort();
    logic [7:0] addr0;
    press(12'($urandom));
    press(12'($urandom));
    @(negedge clk_5M);
    abort = 1'b1;
    @(negedge clk_5M);
    abort = 1'b0;
    m_chunk = 2'd0;
    total++;
    if (obs_vec !== exp_vec() || chunk_idx !== 2'd0) begin
      bad++;
      $display("FAIL abort_clear: got=%h want=%h", obs_vec, exp_vec());
    end
    abort = 1'b1;
    press_raw(12'($urandom));
    abort = 1'b0;
    total++;
    if (obs_vec !== exp_vec()) begin
      bad++;
      $display("FAIL abort_with_press: got=%h want=%h", obs_vec, exp_vec());
    end
    addr0 = m_addr;
    press_word(12'h001, 12'h002, 12'h003);
    wait_we("abort_word");
    total++;
    if (mem_wdata !== 32'h03002001 || mem_addr !== addr0) begin
      bad++;
      $display("FAIL abort_word: got=%h@%h want=03002001@%h", mem_wdata, mem_addr, addr0);
    end
    ack_after(1);
    total++;
    if (obs_vec !== exp_vec()) begin
      bad++;
      $display("FAIL abort_after_ack: got=%h want=%h", obs_vec, exp_vec());
    end
  endtask

  task automatic test_wrap();
    @(negedge clk_5M);
    reset = 1'b1;
    m_reset();
    @(negedge clk_5M);
    reset = 1'b0;
    for (int w = 0; w < 255; w++) begin
      press_word(12'($urandom), 12'($urandom), 12'($urandom));
      wait_we("wrap_we");
      total++;
      if (obs_vec !== exp_vec()) begin
        bad++;
        $display("FAIL wrap_write %0d: got=%h want=%h", w, obs_vec, exp_vec());
      end
      ack_after($urandom_range(0, 3));
    end
    total++;
    if (mem_addr !== 8'hFF || wr_count !== 8'hFF) begin
      bad++;
      $display("FAIL wrap_preload: got addr=%h cnt=%h want ff/ff", mem_addr, wr_count);
    end
    press_word(12'($urandom), 12'($urandom), 12'($urandom));
    wait_we("wrap_last");
    ack_after(2);
    total++;
    if (mem_addr !== 8'h00 || wr_count !== 8'h00 || obs_vec !== exp_vec()) begin
      bad++;
      $display("FAIL wrap_rollover: got=%h want=%h", obs_vec, exp_vec());
    end
  endtask

  task automatic test_reset_mid_write();
    logic [11:0] sw;
    press_word(12'($urandom), 12'($urandom), 12'($urandom));
    wait_we("reset_mid_we");
    @(negedge clk_5M);
    #20 reset = 1'b1;
    m_reset();
    #1;
    total++;
    if (obs_vec !== exp_vec()) begin
      bad++;
      $display("FAIL reset_mid_write: got=%h want=%h", obs_vec, exp_vec());
    end
    #20 reset = 1'b0;
    sw = 12'($urandom);
    press(sw);
    total++;
    if (chunk_idx !== 2'd1 || mem_wdata !== {20'd0, sw} || obs_vec !== exp_vec()) begin
      bad++;
      $display("FAIL reset_restart: got=%h want=%h", obs_vec, exp_vec());
    end
  endtask

  initial begin
    test_reset();
    test_debounce();
    test_full_word();
    test_ack_hold();
    test_abort();
    test_wrap();
    test_reset_mid_write();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
